pmp_check_arbiter: RTL and testbench
====================================

// Module: pmp_check_arbiter
// PURPOSE
// Shares one iterative PMP checker between instruction fetch (req 0) and load/store (req 1).
// Scans the PMP entries lowest index first, one entry per cycle, and returns allow/fault plus the matching entry.
// Sits between the core's IF/LSU address paths and the PMP CSR file, which drives pmpcfg_i and pmpaddr_i.
// PARAMETERS
// NUM_ENTRIES  16  number of PMP entries scanned (1..16)
// XLEN         32  address and pmpaddr width
// PORTS
// clock         in   1                clock, all state on rising edge
// reset         in   1                reset, synchronous, active-high
// req_valid_i   in   2                [0]=IF, [1]=LSU request valid
// req_ready_o   out  2                one-hot grant; request accepted on valid&ready
// req_addr_i    in   2*XLEN           byte address per requester, [XLEN*i +: XLEN]
// req_acc_i     in   2*2              access type per requester: 00=R 01=W 10=X 11=reserved (always fault)
// req_priv_i    in   2*2              privilege per requester: 11=M 01=S 00=U
// resp_valid_o  out  2                one-hot response valid to the granted requester
// resp_ready_i  in   2                requester accepts response
// resp_fault_o  out  1                1=access denied; meaningful only while resp_valid_o != 0
// resp_hit_o    out  1                1=an entry matched
// resp_entry_o  out  4                index of the matching entry (0 when resp_hit_o=0)
// pmpcfg_i      in   NUM_ENTRIES*8    live cfg bytes: [7]=L [4:3]=A [2]=X [1]=W [0]=R
// pmpaddr_i     in   NUM_ENTRIES*XLEN live pmpaddr values (address bits [33:2])
// pmp_wr_i      in   1                pulse: CSR file wrote any pmpcfg/pmpaddr this cycle
// busy_o        out  1                1 in SCAN or RESP
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0 (IF favoured), idx=0. All outputs 0. Reset mid-scan or mid-response discards the transaction, with no response.
// - FSM IDLE->SCAN->RESP->IDLE.
// - IDLE: req_ready_o is combinational. Both valid: grant rr_ptr side. One valid: grant it.
//   On accept, latch addr/acc/priv/requester, idx<=0, go SCAN.
// - SCAN: each cycle, evaluate entry idx against the latched 34-bit address {2'b0,addr}.
//   A=00 OFF: never matches.
//   A=01 TOR: match if lo<=a<hi, with hi={pmpaddr[idx],2'b00} and lo=(idx==0)?0:{pmpaddr[idx-1],2'b00}. hi<=lo never matches.
//   A=10 NA4: match if a[33:2]==pmpaddr[idx].
//   A=11 NAPOT: t=count of trailing ones in pmpaddr[idx]; region size 2^(t+3); compare a[33:t+3] with pmpaddr[idx] above bit t.
//   All-ones pmpaddr matches the whole space.
// - Match: record cfg and idx, go RESP. First match wins; no further entries are scanned.
// - No match at idx==NUM_ENTRIES-1: go RESP, hit=0, fault=(priv!=M).
// - Permission on hit: if priv==M and L==0, allow. Otherwise allow iff the cfg bit for acc (R/W/X) is set. acc=11 always faults.
// - pmp_wr_i asserted in SCAN: idx<=0 and the scan restarts; any match found that cycle is discarded. Ignored in IDLE and RESP.
// - RESP: resp_valid_o one-hot to the latched requester; fault/hit/entry held stable until resp_ready_i of that requester.
//   On handshake: go IDLE, rr_ptr<=~granted.
// - Latency: accept in cycle T; entry k is evaluated in T+1+k; resp_valid_o rises in T+2+k.
//   No match: resp_valid_o rises in T+1+NUM_ENTRIES.
// - A new request is accepted at the earliest in the cycle after the response handshake. One outstanding transaction total.
// - Address arithmetic is 34-bit unsigned, with no wrap: TOR hi=0 never matches.
// TESTING
// - Reset, all cfg=0, U-mode LSU read 0x1000 -> resp in T+17, hit=0, fault=1. Same access in M-mode -> fault=0.
// - cfg2: A=TOR R=1, pmpaddr1=0x400, pmpaddr2=0x800. U read 0x1000 -> hit=1 entry=2 fault=0, resp at T+4.
//   U write 0x1000 -> fault=1. Address 0x2000 -> miss, fault=1.
// - cfg0: NAPOT L=1 X=0, pmpaddr0=0x1FF (4 KiB at 0). M-mode fetch 0x0FFC -> hit entry 0, fault=1 (lock applies to M).
// - Both valid in the same cycle after reset: IF granted first, LSU next. Then both again -> LSU first (round-robin).
// - pmp_wr_i pulse in cycle T+3 of a scan for entry 5 -> scan restarts; resp arrives in T+10. New cfg values are used.
// - resp_ready_i held low 5 cycles -> outputs stable, no new grant. Reset asserted during SCAN -> no resp_valid_o, IDLE next cycle.

Source files
------------

// File: rtl/pmp_check_arbiter.sv
// pmp_check_arbiter
//   Shares one iterative PMP checker between instruction fetch (requester 0)
//   and load/store (requester 1). A single outstanding transaction scans the
//   PMP entries lowest index first, one entry per cycle, and returns
//   allow/fault, hit and the index of the matching entry.
//
// Ports
//   clock, reset           clock; synchronous active-high reset
//   req_valid_i/ready_o    per-requester request handshake (ready is one-hot)
//   req_addr_i/acc_i/priv_i per-requester byte address, access type, privilege
//   resp_valid_o/ready_i   one-hot response handshake to the granted requester
//   resp_fault_o/hit_o/entry_o  check result, held while resp_valid_o != 0
//   pmpcfg_i, pmpaddr_i    live PMP CSR contents
//   pmp_wr_i               CSR write pulse; restarts an in-flight scan
//   busy_o                 transaction in flight (SCAN or RESP)
module pmp_check_arbiter #(
   parameter int NUM_ENTRIES = 16,
   parameter int XLEN        = 32
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [1:0]                  req_valid_i,
   output logic [1:0]                  req_ready_o,
   input  logic [2*XLEN-1:0]           req_addr_i,
   input  logic [3:0]                  req_acc_i,
   input  logic [3:0]                  req_priv_i,
   output logic [1:0]                  resp_valid_o,
   input  logic [1:0]                  resp_ready_i,
   output logic                        resp_fault_o,
   output logic                        resp_hit_o,
   output logic [3:0]                  resp_entry_o,
   input  logic [NUM_ENTRIES*8-1:0]    pmpcfg_i,
   input  logic [NUM_ENTRIES*XLEN-1:0] pmpaddr_i,
   input  logic                        pmp_wr_i,
   output logic                        busy_o
);

   localparam int         AW       = XLEN + 2;
   localparam logic [3:0] LAST_IDX = 4'(NUM_ENTRIES - 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

   state_t          r_state, w_state_nxt;
   logic            r_rr_ptr, r_req;
   logic [3:0]      r_idx;
   logic [XLEN-1:0] r_addr;
   logic [1:0]      r_acc, r_priv;
   logic            r_fault, r_hit;
   logic [3:0]      r_entry;

   // Entries padded to 16 so the 4-bit scan index never selects out of range
   logic [7:0]      w_cfg   [16];
   logic [XLEN-1:0] w_paddr [16];

   for (genvar g = 0; g < 16; g++) begin : g_ent
      if (g < NUM_ENTRIES) begin : g_live
         assign w_cfg[g]   = pmpcfg_i[g*8 +: 8];
         assign w_paddr[g] = pmpaddr_i[g*XLEN +: XLEN];
      end else begin : g_pad
         assign w_cfg[g]   = '0;
         assign w_paddr[g] = '0;
      end
   end

   // Arbitration: round-robin pointer only matters when both are valid
   logic w_gsel, w_accept;
   assign w_gsel      = (&req_valid_i) ? r_rr_ptr : req_valid_i[1];
   assign w_accept    = (r_state == S_IDLE) && (|req_valid_i) && !reset;
   assign req_ready_o = w_accept ? (w_gsel ? 2'b10 : 2'b01) : 2'b00;

   // Match / permission evaluation for entry r_idx
   logic [7:0]      w_ccfg;
   logic [XLEN-1:0] w_cur, w_prev, w_tmask;
   logic [AW-1:0]   w_a, w_hi, w_lo;
   logic            w_match, w_perm_fault, w_miss_fault, w_unused;

   always_comb begin
      w_match      = 1'b0;
      w_perm_fault = 1'b1;
      w_ccfg       = w_cfg[r_idx];
      w_cur        = w_paddr[r_idx];
      w_prev       = (r_idx == 4'd0) ? '0 : w_paddr[r_idx - 4'd1];
      w_a          = {2'b00, r_addr};
      w_hi         = {w_cur, 2'b00};
      w_lo         = {w_prev, 2'b00};
      // Bits [t:0] set where t = trailing-ones count; all ones when pmpaddr is all ones
      w_tmask      = w_cur ^ (w_cur + XLEN'(1));
      case (w_ccfg[4:3])
         2'b01:   w_match = (w_a >= w_lo) && (w_a < w_hi);
         2'b10:   w_match = (w_a[AW-1:2] == w_cur);
         2'b11:   w_match = ((w_a[AW-1:2] ^ w_cur) & ~w_tmask) == '0;
         default: w_match = 1'b0;
      endcase
      if (r_acc == 2'b11)                       w_perm_fault = 1'b1;
      else if (r_priv == 2'b11 && !w_ccfg[7])   w_perm_fault = 1'b0;
      else                                      w_perm_fault = !w_ccfg[{1'b0, r_acc}];
      w_miss_fault = (r_acc == 2'b11) || (r_priv != 2'b11);
   end

   assign w_unused = ^w_ccfg[6:5];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_SCAN;
         S_SCAN:  if (!pmp_wr_i && (w_match || r_idx == LAST_IDX)) w_state_nxt = S_RESP;
         S_RESP:  if (resp_ready_i[r_req]) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= 1'b0;
         r_req    <= 1'b0;
         r_idx    <= 4'd0;
         r_addr   <= '0;
         r_acc    <= 2'b00;
         r_priv   <= 2'b00;
         r_fault  <= 1'b0;
         r_hit    <= 1'b0;
         r_entry  <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_req  <= w_gsel;
               r_addr <= w_gsel ? req_addr_i[XLEN +: XLEN] : req_addr_i[0 +: XLEN];
               r_acc  <= w_gsel ? req_acc_i[3:2]  : req_acc_i[1:0];
               r_priv <= w_gsel ? req_priv_i[3:2] : req_priv_i[1:0];
               r_idx  <= 4'd0;
            end
            S_SCAN: begin
               // A CSR write invalidates whatever this cycle found
               if (pmp_wr_i) r_idx <= 4'd0;
               else if (w_match) begin
                  r_hit   <= 1'b1;
                  r_entry <= r_idx;
                  r_fault <= w_perm_fault;
               end else if (r_idx == LAST_IDX) begin
                  r_hit   <= 1'b0;
                  r_entry <= 4'd0;
                  r_fault <= w_miss_fault;
               end else r_idx <= r_idx + 4'd1;
            end
            S_RESP: if (resp_ready_i[r_req]) r_rr_ptr <= ~r_req;
            default: ;
         endcase
      end
   end

   assign resp_valid_o = (r_state == S_RESP) ? (r_req ? 2'b10 : 2'b01) : 2'b00;
   assign resp_fault_o = r_fault;
   assign resp_hit_o   = r_hit;
   assign resp_entry_o = r_entry;
   assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_pmp_check_arbiter.sv
module tb_pmp_check_arbiter;
   logic          clock = 1'b0, reset = 1'b1;
   logic [1:0]    req_valid_i = 2'b00, req_ready_o;
   logic [63:0]   req_addr_i = '0;
   logic [3:0]    req_acc_i = '0, req_priv_i = '0;
   logic [1:0]    resp_valid_o, resp_ready_i = 2'b00;
   logic          resp_fault_o, resp_hit_o;
   logic [3:0]    resp_entry_o;
   logic [127:0]  pmpcfg = '0;
   logic [511:0]  pmpaddr = '0;
   logic          pmp_wr_i = 1'b0, busy_o;

   int errors = 0, checks = 0;
   bit m_rr = 1'b0;   // reference round-robin favourite: 0=IF, 1=LSU

   always #5 clock = ~clock;

   pmp_check_arbiter #(.NUM_ENTRIES(16), .XLEN(32)) dut (
      .clock(clock), .reset(reset),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_acc_i(req_acc_i), .req_priv_i(req_priv_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_fault_o(resp_fault_o), .resp_hit_o(resp_hit_o), .resp_entry_o(resp_entry_o),
      .pmpcfg_i(pmpcfg), .pmpaddr_i(pmpaddr), .pmp_wr_i(pmp_wr_i), .busy_o(busy_o));

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Reference: walk entries as address ranges with plain 64-bit arithmetic
   task automatic model(input logic [31:0] a, input logic [1:0] acc, input logic [1:0] pr,
                        output logic hit, output logic [3:0] ent, output logic flt);
      longint unsigned aa, lo, hi, pa, base, size;
      int t;
      logic [7:0] c, hc;
      logic m;
      aa = 64'(a); hit = 1'b0; ent = 4'd0; hc = 8'd0;
      for (int i = 0; i < 16; i++) begin
         c = pmpcfg[i*8 +: 8]; pa = 64'(pmpaddr[i*32 +: 32]); m = 1'b0;
         case (c[4:3])
            2'b01: begin
               if (i == 0) lo = 0; else lo = 64'(pmpaddr[(i-1)*32 +: 32]) << 2;
               hi = pa << 2;
               m = (aa >= lo) && (aa < hi);
            end
            2'b10: m = ((aa >> 2) == pa);
            2'b11: begin
               t = 0;
               while (t < 32 && pa[t]) t++;
               size = 64'd1 << (t + 3);
               base = (pa << 2) & ~(size - 1);
               m = (aa >= base) && (aa < base + size);
            end
            default: m = 1'b0;
         endcase
         if (m) begin hit = 1'b1; ent = 4'(i); hc = c; break; end
      end
      if (acc == 2'b11)                 flt = 1'b1;
      else if (!hit)                    flt = (pr != 2'b11);
      else if (pr == 2'b11 && !hc[7])   flt = 1'b0;
      else                              flt = !hc[acc];
   endtask

   task automatic set_req(input int s, input logic [31:0] a, input logic [1:0] acc, input logic [1:0] pr);
      req_addr_i[s*32 +: 32] = a;
      req_acc_i[s*2 +: 2]    = acc;
      req_priv_i[s*2 +: 2]   = pr;
      req_valid_i[s]         = 1'b1;
   endtask

   // Present a single request; returns ready seen before the accepting edge
   task automatic issue(input int s, input logic [31:0] a, input logic [1:0] acc, input logic [1:0] pr,
                        output logic [1:0] rdy);
      @(negedge clock);
      set_req(s, a, acc, pr);
      #1 rdy = req_ready_o;
      @(posedge clock);
      #1 req_valid_i[s] = 1'b0;
   endtask

   // Counts cycles after accept (first negedge is cycle 'base'); stops on resp_valid_o
   task automatic wait_resp(input int base, output int lat);
      int n;
      n = base;
      @(negedge clock);
      while (resp_valid_o == 2'b00 && n < base + 100) begin
         @(negedge clock);
         n++;
      end
      lat = n;
   endtask

   task automatic handshake(input int s);
      resp_ready_i[s] = 1'b1;
      @(posedge clock);
      #1 resp_ready_i = 2'b00;
      m_rr = (s == 0);
   endtask

   task automatic do_reset();
      reset = 1'b1; req_valid_i = 2'b00; resp_ready_i = 2'b00; pmp_wr_i = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      m_rr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid_i = 2'b11;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({req_ready_o, resp_valid_o, busy_o, resp_hit_o, resp_fault_o, resp_entry_o} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 0",
                  {req_ready_o, resp_valid_o, busy_o, resp_hit_o, resp_fault_o, resp_entry_o});
      end
      do_reset();
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
   endtask

   task automatic test_miss();
      logic [1:0] rdy; int lat;
      pmpcfg = '0; pmpaddr = '0;
      issue(1, 32'h1000, 2'b00, 2'b00, rdy);
      checks++;
      if (rdy !== 2'b10) begin errors++; $display("FAIL miss_grant: got %b want 10", rdy); end
      wait_resp(1, lat);
      checks++;
      if (lat !== 17) begin errors++; $display("FAIL miss_latency: got %0d want 17", lat); end
      checks++;
      if ({resp_valid_o, resp_hit_o, resp_entry_o, resp_fault_o} !== {2'b10, 1'b0, 4'd0, 1'b1}) begin
         errors++;
         $display("FAIL miss_u_resp: got %b want 10_0_0000_1", {resp_valid_o, resp_hit_o, resp_entry_o, resp_fault_o});
      end
      handshake(1);
      issue(1, 32'h1000, 2'b00, 2'b11, rdy);
      wait_resp(1, lat);
      checks++;
      if (lat !== 17 || {resp_hit_o, resp_fault_o} !== 2'b00) begin
         errors++;
         $display("FAIL miss_m_resp: got lat=%0d hit=%b fault=%b want lat=17 hit=0 fault=0", lat, resp_hit_o, resp_fault_o);
      end
      handshake(1);
   endtask

   task automatic test_tor();
      logic [1:0] rdy; int lat;
      pmpcfg = '0; pmpaddr = '0;
      pmpcfg[2*8 +: 8]   = 8'h09;
      pmpaddr[1*32 +: 32] = 32'h400;
      pmpaddr[2*32 +: 32] = 32'h800;
      issue(1, 32'h1000, 2'b00, 2'b00, rdy);
      wait_resp(1, lat);
      checks++;
      if (lat !== 4 || {resp_valid_o, resp_hit_o, resp_entry_o, resp_fault_o} !== {2'b10, 1'b1, 4'd2, 1'b0}) begin
         errors++;
         $display("FAIL tor_read: got lat=%0d resp=%b want lat=4 resp=10_1_0010_0", lat,
                  {resp_valid_o, resp_hit_o, resp_entry_o, resp_fault_o});
      end
      handshake(1);
      issue(1, 32'h1000, 2'b01, 2'b00, rdy);
      wait_resp(1, lat);
      checks++;
      if (lat !== 4 || {resp_hit_o, resp_entry_o, resp_fault_o} !== {1'b1, 4'd2, 1'b1}) begin
         errors++;
         $display("FAIL tor_write: got lat=%0d hit=%b entry=%0d fault=%b want 4 1 2 1", lat, resp_hit_o, resp_entry_o, resp_fault_o);
      end
      handshake(1);
      issue(1, 32'h2000, 2'b00, 2'b00, rdy);
      wait_resp(1, lat);
      checks++;
      if (lat !== 17 || {resp_hit_o, resp_fault_o} !== 2'b01) begin
         errors++;
         $display("FAIL tor_top_edge: got lat=%0d hit=%b fault=%b want 17 0 1", lat, resp_hit_o, resp_fault_o);
      end
      handshake(1);
   endtask

   task automatic test_napot_lock();
      logic [1:0] rdy; int lat;
      pmpcfg = '0; pmpaddr = '0;
      pmpcfg[7:0]   = 8'h98;
      pmpaddr[31:0] = 32'h1FF;
      issue(0, 32'h0FFC, 2'b10, 2'b11, rdy);
      checks++;
      if (rdy !== 2'b01) begin errors++; $display("FAIL napot_grant: got %b want 01", rdy); end
      wait_resp(1, lat);
      checks++;
      if (lat !== 2 || {resp_valid_o, resp_hit_o, resp_entry_o, resp_fault_o} !== {2'b01, 1'b1, 4'd0, 1'b1}) begin
         errors++;
         $display("FAIL napot_locked_m: got lat=%0d resp=%b want lat=2 resp=01_1_0000_1", lat,
                  {resp_valid_o, resp_hit_o, resp_entry_o, resp_fault_o});
      end
      handshake(0);
      issue(0, 32'h1000, 2'b10, 2'b11, rdy);
      wait_resp(1, lat);
      checks++;
      if (lat !== 17 || {resp_hit_o, resp_fault_o} !== 2'b00) begin
         errors++;
         $display("FAIL napot_outside: got lat=%0d hit=%b fault=%b want 17 0 0", lat, resp_hit_o, resp_fault_o);
      end
      handshake(0);
   endtask

   task automatic test_round_robin();
      int lat;
      do_reset();
      pmpcfg = '0; pmpaddr = '0;
      pmpcfg[7:0] = 8'h1F; pmpaddr[31:0] = 32'hFFFF_FFFF;
      for (int r = 0; r < 2; r++) begin
         @(negedge clock);
         set_req(0, 32'h100, 2'b10, 2'b00);
         set_req(1, 32'h200, 2'b00, 2'b00);
         #1;
         checks++;
         if (req_ready_o !== (m_rr ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL rr_both_%0d: got %b want %b", r, req_ready_o, m_rr ? 2'b10 : 2'b01);
         end
         @(posedge clock);
         #1 req_valid_i[m_rr] = 1'b0;
         wait_resp(1, lat);
         checks++;
         if (resp_valid_o !== (m_rr ? 2'b10 : 2'b01) || lat !== 2) begin
            errors++; $display("FAIL rr_resp_%0d: got valid=%b lat=%0d want %b lat=2", r, resp_valid_o, lat, m_rr ? 2'b10 : 2'b01);
         end
         handshake(m_rr ? 1 : 0);
      end
      req_valid_i = 2'b00;
   endtask

   task automatic test_pmp_wr();
      logic [1:0] rdy; int lat;
      pmpcfg = '0; pmpaddr = '0;
      pmpcfg[5*8 +: 8]    = 8'h11;
      pmpaddr[5*32 +: 32] = 32'hC00;
      issue(1, 32'h3000, 2'b00, 2'b00, rdy);
      @(posedge clock);
      @(posedge clock);
      #1 pmp_wr_i = 1'b1; pmpcfg[5*8 +: 8] = 8'h10;
      @(posedge clock);
      #1 pmp_wr_i = 1'b0;
      wait_resp(4, lat);
      checks++;
      if (lat !== 10) begin errors++; $display("FAIL pmpwr_latency: got %0d want 10", lat); end
      checks++;
      if ({resp_hit_o, resp_entry_o, resp_fault_o} !== {1'b1, 4'd5, 1'b1}) begin
         errors++; $display("FAIL pmpwr_newcfg: got hit=%b entry=%0d fault=%b want 1 5 1", resp_hit_o, resp_entry_o, resp_fault_o);
      end
      handshake(1);
   endtask

   task automatic test_backpressure();
      logic [1:0] rdy; logic [7:0] snap; int lat;
      pmpcfg = '0; pmpaddr = '0;
      pmpcfg[7:0] = 8'h1F; pmpaddr[31:0] = 32'hFFFF_FFFF;
      issue(0, 32'h40, 2'b00, 2'b00, rdy);
      wait_resp(1, lat);
      snap = {resp_valid_o, resp_hit_o, resp_entry_o, resp_fault_o};
      checks++;
      if (snap !== {2'b01, 1'b1, 4'd0, 1'b0}) begin
         errors++; $display("FAIL bp_first: got %b want 01_1_0000_0", snap);
      end
      set_req(1, 32'h80, 2'b01, 2'b00);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         checks++;
         if ({resp_valid_o, resp_hit_o, resp_entry_o, resp_fault_o} !== snap || req_ready_o !== 2'b00) begin
            errors++;
            $display("FAIL bp_hold_%0d: got resp=%b ready=%b want resp=%b ready=00", i,
                     {resp_valid_o, resp_hit_o, resp_entry_o, resp_fault_o}, req_ready_o, snap);
         end
      end
      handshake(0);
      checks++;
      if (resp_valid_o !== 2'b00 || req_ready_o !== 2'b10) begin
         errors++; $display("FAIL bp_after: got valid=%b ready=%b want 00 10", resp_valid_o, req_ready_o);
      end
      @(posedge clock);
      #1 req_valid_i[1] = 1'b0;
      wait_resp(1, lat);
      checks++;
      if (lat !== 2 || {resp_valid_o, resp_fault_o} !== 3'b100) begin
         errors++; $display("FAIL bp_second: got lat=%0d valid=%b fault=%b want 2 10 0", lat, resp_valid_o, resp_fault_o);
      end
      handshake(1);
   endtask

   task automatic test_reset_mid_scan();
      logic [1:0] rdy; int seen, lat;
      pmpcfg = '0; pmpaddr = '0;
      issue(1, 32'h1000, 2'b00, 2'b00, rdy);
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0; m_rr = 1'b0;
      checks++;
      if ({busy_o, resp_valid_o} !== 3'b000) begin
         errors++; $display("FAIL rst_scan_idle: got busy=%b valid=%b want 0 00", busy_o, resp_valid_o);
      end
      seen = 0;
      repeat (20) begin
         @(negedge clock);
         if (resp_valid_o != 2'b00) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL rst_scan_noresp: got %0d resp cycles want 0", seen); end
      @(negedge clock);
      set_req(0, 32'h10, 2'b00, 2'b11);
      set_req(1, 32'h20, 2'b00, 2'b11);
      #1;
      checks++;
      if (req_ready_o !== 2'b01) begin errors++; $display("FAIL rst_scan_rrptr: got %b want 01", req_ready_o); end
      @(posedge clock);
      #1 req_valid_i = 2'b00;
      wait_resp(1, lat);
      handshake(0);
   endtask

   task automatic test_random();
      logic [1:0] rdy, acc, pr;
      logic [31:0] a, p;
      logic [7:0] c;
      logic eh, ef;
      logic [3:0] ee;
      int lat, s, t, elat;
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < 16; i++) begin
            c = 8'($urandom);
            c[6:5] = 2'b00;
            if ($urandom_range(0, 2) == 0) c[4:3] = 2'b00;
            p = 32'($urandom_range(0, 'h900));
            if (c[4:3] == 2'b11) begin
               t = $urandom_range(0, 6);
               p = (p & ~((32'd1 << (t + 1)) - 1)) | ((32'd1 << t) - 1);
               if ($urandom_range(0, 15) == 0) p = 32'hFFFF_FFFF;
            end
            pmpcfg[i*8 +: 8] = c;
            pmpaddr[i*32 +: 32] = p;
         end
         a   = 32'($urandom_range(0, 'h2400));
         s   = $urandom_range(0, 1);
         acc = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 2)) 0: pr = 2'b00; 1: pr = 2'b01; default: pr = 2'b11; endcase
         model(a, acc, pr, eh, ee, ef);
         elat = eh ? 2 + int'(ee) : 17;
         issue(s, a, acc, pr, rdy);
         checks++;
         if (rdy !== (s == 1 ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL rand_grant_%0d: got %b want %b", it, rdy, s == 1 ? 2'b10 : 2'b01);
         end
         wait_resp(1, lat);
         checks++;
         if (lat !== elat) begin errors++; $display("FAIL rand_lat_%0d: got %0d want %0d", it, lat, elat); end
         checks++;
         if ({resp_valid_o, resp_hit_o, resp_entry_o, resp_fault_o} !== {(s == 1 ? 2'b10 : 2'b01), eh, ee, ef}) begin
            errors++;
            $display("FAIL rand_resp_%0d: addr=%h acc=%b priv=%b got %b want %b", it, a, acc, pr,
                     {resp_valid_o, resp_hit_o, resp_entry_o, resp_fault_o}, {(s == 1 ? 2'b10 : 2'b01), eh, ee, ef});
         end
         repeat ($urandom_range(0, 2)) @(negedge clock);
         handshake(s);
      end
   endtask

   initial begin
      test_reset();
      test_miss();
      test_tor();
      test_napot_lock();
      test_round_robin();
      test_pmp_wr();
      test_backpressure();
      test_reset_mid_scan();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
